uart_rx: RTL and testbench

UART receiver for a 115200 baud link at 8 data bits, 1 stop bit, no parity, clocked at 100 MHz. It is the receive-side counterpart of the existing uart_tx.
- Synchronises the asynchronous rx line and validates the start bit.
- Samples each bit at its centre, LSB first.
- Presents each received byte on a one-entry valid/ready output register.
- Flags framing errors and overruns so the core state machine can read console input.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART timing defaults and receiver state encoding.
// Both uart_tx and uart_rx take their bit timing from here.
package uart_pkg;

    localparam int CLK_FREQ_HZ          = 100000000;
    localparam int BAUD                 = 115200;
    localparam int CLK_PER_BIT_DEFAULT  = CLK_FREQ_HZ / BAUD;

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// The reset value is a parameter so idle-high and idle-low lines can both use it.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, centre-of-bit sampling, LSB first, with a one-entry
// valid/ready output register and single-cycle framing/overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = CLK_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLK_PER_BIT);

    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_BIT - 1);

    rx_state_t        state;
    logic             rx_s;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tick;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign tick = (baud_cnt == '0);

    // Output handshake: a byte transfers on any rising edge where valid && ready.
    // valid stays high and data_out stays frozen until that edge; ready is a
    // don't-care while valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_HIGH;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (valid && ready)
                valid <= 1'b0;

            if (state == START || state == DATA || state == STOP)
                baud_cnt <= tick ? FULL_RELOAD : baud_cnt - 1'b1;

            case (state)
                WAIT_HIGH: begin
                    if (rx_s)
                        state <= IDLE;
                end
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= HALF_RELOAD;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        busy <= 1'b0;
                        if (rx_s) begin
                            state <= IDLE;
                            // A consume in this same cycle frees the slot for the new byte.
                            if (!valid || ready) begin
                                data_out <= shreg;
                                valid    <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                default: begin
                    state <= WAIT_HIGH;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, overrun, glitch rejection, reset abort
// and baud tolerance, checked with immediate assertions.
module tb_uart_rx;

    localparam int CPB  = 160;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_eval = 0;
    int n_fail = 0;
    int cyc    = 0;

    uart_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation counters, sampled on the falling edge.
    int         n_vrise = 0, n_vhigh = 0, n_fe = 0, n_ov = 0, n_unstable = 0;
    int         vrise_cyc = 0, fe_cyc = 0, ov_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
    logic [7:0] vdata = 8'h00, data_q = 8'h00;
    logic       valid_q = 1'b0, ready_q = 1'b0, busy_q = 1'b0;

    always @(negedge clk) begin
        if (valid && !valid_q) begin
            n_vrise   = n_vrise + 1;
            vrise_cyc = cyc;
            vdata     = data_out;
        end
        if (valid) n_vhigh = n_vhigh + 1;
        if (frame_err) begin
            n_fe   = n_fe + 1;
            fe_cyc = cyc;
        end
        if (overrun) begin
            n_ov   = n_ov + 1;
            ov_cyc = cyc;
        end
        if (busy && !busy_q) busy_rise_cyc = cyc;
        if (!busy && busy_q) busy_fall_cyc = cyc;
        if (valid && valid_q && !ready_q && data_out !== data_q) n_unstable = n_unstable + 1;
        valid_q = valid;
        ready_q = ready;
        busy_q  = busy;
        data_q  = data_out;
    end

    int b_vrise, b_vhigh, b_fe, b_ov;

    task automatic snap();
        b_vrise = n_vrise;
        b_vhigh = n_vhigh;
        b_fe    = n_fe;
        b_ov    = n_ov;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval = n_eval + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int p, input logic stop_bit, output int t0);
        @(posedge clk);
        #1;
        t0 = cyc;
        rx = 1'b0;
        hold(p);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(p);
        end
        rx = stop_bit;
        hold(p);
        rx = 1'b1;
    endtask

    int t0, t1;

    initial begin
        rx    = 1'b1;
        ready = 1'b0;
        rst   = 1'b1;
        hold(5);
        check("rst_data",  data_out,  32'h00);
        check("rst_valid", valid,     32'h0);
        check("rst_busy",  busy,      32'h0);
        check("rst_fe",    frame_err, 32'h0);
        check("rst_ov",    overrun,   32'h0);
        rst = 1'b0;
        hold(10);

        // Single byte with ready held high: one-cycle valid pulse.
        ready = 1'b1;
        snap();
        send(8'h55, CPB, 1'b1, t0);
        hold(5);
        check("t1_data",     vdata,             32'h55);
        check("t1_rise_cyc", vrise_cyc,         t0 + LAT);
        check("t1_vwidth",   n_vhigh - b_vhigh, 32'd1);
        check("t1_fe",       n_fe - b_fe,       32'd0);
        check("t1_ov",       n_ov - b_ov,       32'd0);
        check("t1_vlow",     valid,             32'h0);

        // Back-to-back bytes with ready low: second byte overruns.
        ready = 1'b0;
        snap();
        send(8'hA3, CPB, 1'b1, t0);
        check("t2_data1",  data_out, 32'hA3);
        check("t2_valid1", valid,    32'h1);
        send(8'h00, CPB, 1'b1, t1);
        check("t2_ov_cnt",   n_ov - b_ov,       32'd1);
        check("t2_ov_cyc",   ov_cyc,            t1 + LAT);
        check("t2_hold",     data_out,          32'hA3);
        check("t2_valid2",   valid,             32'h1);
        check("t2_vrise",    n_vrise - b_vrise, 32'd1);
        check("t2_stable",   n_unstable,        32'd0);
        ready = 1'b1;
        check("t2_pre_take", valid, 32'h1);
        hold(1);
        check("t2_taken",    valid, 32'h0);
        hold(20);

        // Short low glitch: start sample sees high and the receiver returns to idle.
        snap();
        @(posedge clk);
        #1;
        t0 = cyc;
        rx = 1'b0;
        hold(40);
        rx = 1'b1;
        hold(200);
        check("t3_busy_rise", busy_rise_cyc,     t0 + 3);
        check("t3_busy_fall", busy_fall_cyc,     t0 + 3 + HALF);
        check("t3_no_valid",  n_vrise - b_vrise, 32'd0);
        check("t3_no_flags",  (n_fe - b_fe) + (n_ov - b_ov), 32'd0);
        send(8'h4D, CPB, 1'b1, t0);
        hold(5);
        check("t3_data",  vdata,             32'h4D);
        check("t3_vrise", n_vrise - b_vrise, 32'd1);
        hold(20);

        // Low stop bit followed by a long break.
        snap();
        send(8'h41, CPB, 1'b0, t0);
        rx = 1'b0;
        hold(400);
        check("t4_fe_cnt",  n_fe - b_fe,       32'd1);
        check("t4_fe_cyc",  fe_cyc,            t0 + LAT);
        check("t4_no_val",  n_vrise - b_vrise, 32'd0);
        check("t4_idle",    busy,              32'h0);
        rx = 1'b1;
        hold(20);
        send(8'h42, CPB, 1'b1, t0);
        hold(5);
        check("t4_data",  vdata,             32'h42);
        check("t4_vrise", n_vrise - b_vrise, 32'd1);
        hold(20);

        // Reset pulse in the middle of data bit 3 aborts the frame.
        snap();
        @(posedge clk);
        #1;
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = t0[0] ? 1'b1 : 1'b1;
            rx = (8'h7E >> i) & 8'h01 ? 1'b1 : 1'b0;
            hold(CPB);
        end
        rx = 1'b1;
        hold(CPB / 2);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        check("t5_data",  data_out,  32'h00);
        check("t5_valid", valid,     32'h0);
        check("t5_busy",  busy,      32'h0);
        check("t5_fe",    frame_err, 32'h0);
        check("t5_ov",    overrun,   32'h0);
        hold(3 * CPB);
        check("t5_no_val",   n_vrise - b_vrise,            32'd0);
        check("t5_no_flags", (n_fe - b_fe) + (n_ov - b_ov), 32'd0);
        send(8'h7E, CPB, 1'b1, t0);
        hold(5);
        check("t5_data2", vdata,             32'h7E);
        check("t5_vrise", n_vrise - b_vrise, 32'd1);
        hold(20);

        // Baud tolerance: transmitter about 2% fast and 2% slow.
        snap();
        send(8'h50, CPB - 3, 1'b1, t0);
        hold(CPB);
        check("t6_fast", vdata, 32'h50);
        send(8'h50, CPB + 3, 1'b1, t0);
        hold(5);
        check("t6_slow",  vdata,             32'h50);
        check("t6_vrise", n_vrise - b_vrise, 32'd2);
        check("t6_flags", (n_fe - b_fe) + (n_ov - b_ov), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
